// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch stage: state encoding, widths
// and the reset PC default.
package ifu_pkg;

   localparam int XLEN = 32;
   localparam int CNT_W = 8;
   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h8000_0000;

   typedef enum logic [1:0] {
      S_REQ   = 2'd0,
      S_WAIT  = 2'd1,
      S_VALID = 2'd2,
      S_NEXT  = 2'd3
   } fetch_state_e;

   function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
      return addr[1:0] != 2'b00;
   endfunction

endpackage

// File: rtl/ifu_timeout_cnt.sv
// Response-wait counter for the fetch stage; flags the last cycle a memory
// response may arrive before the fetch is declared faulted.
module ifu_timeout_cnt
   import ifu_pkg::*;
#(
   parameter int TIMEOUT = 16
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clear_i,
   input  logic enable_i,
   output logic expired_o
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (enable_i) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expired_o = (count_q == LAST);

endmodule

// File: rtl/ifu_fetch.sv
// Multi-cycle instruction fetch stage: one memory request per instruction,
// buffered result handed to decode, advanced by the write-back next PC.
module ifu_fetch
   import ifu_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int              TIMEOUT  = 16
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            pc_next_valid_i,
   input  logic [XLEN-1:0] pc_next_i,
   output logic            imem_req_valid_o,
   input  logic            imem_req_ready_i,
   output logic [XLEN-1:0] imem_req_addr_o,
   input  logic            imem_rsp_valid_i,
   output logic            imem_rsp_ready_o,
   input  logic [XLEN-1:0] imem_rsp_data_i,
   input  logic            imem_rsp_err_i,
   output logic            inst_valid_o,
   input  logic            inst_ready_i,
   output logic [XLEN-1:0] inst_o,
   output logic [XLEN-1:0] inst_pc_o,
   output logic            fetch_fault_o,
   output logic [XLEN-1:0] pc_o
);

   fetch_state_e    state_q;
   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] inst_q;
   logic [XLEN-1:0] instPc_q;
   logic            fault_q;

   logic timeoutHit;
   logic acceptNext;

   // The counter only runs while waiting, so it restarts from zero on every fetch.
   ifu_timeout_cnt #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout_cnt (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .clear_i   (state_q != S_WAIT),
      .enable_i  ((state_q == S_WAIT) && !imem_rsp_valid_i),
      .expired_o (timeoutHit)
   );

   assign acceptNext = pc_next_valid_i &&
                       (((state_q == S_VALID) && inst_ready_i) || (state_q == S_NEXT));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= S_REQ;
         pc_q     <= RESET_PC;
         inst_q   <= '0;
         instPc_q <= '0;
         fault_q  <= 1'b0;
      end else begin
         case (state_q)
            S_REQ: begin
               if (imem_req_ready_i) begin
                  state_q <= S_WAIT;
               end
            end
            // A response landing on the timeout cycle still counts as a good fetch.
            S_WAIT: begin
               if (imem_rsp_valid_i) begin
                  inst_q   <= imem_rsp_data_i;
                  instPc_q <= pc_q;
                  fault_q  <= imem_rsp_err_i;
                  state_q  <= S_VALID;
               end else if (timeoutHit) begin
                  inst_q   <= '0;
                  instPc_q <= pc_q;
                  fault_q  <= 1'b1;
                  state_q  <= S_VALID;
               end
            end
            S_VALID, S_NEXT: begin
               if (acceptNext) begin
                  pc_q <= pc_next_i;
                  if (is_misaligned(pc_next_i)) begin
                     inst_q   <= '0;
                     instPc_q <= pc_next_i;
                     fault_q  <= 1'b1;
                     state_q  <= S_VALID;
                  end else begin
                     state_q <= S_REQ;
                  end
               end else if ((state_q == S_VALID) && inst_ready_i) begin
                  state_q <= S_NEXT;
               end
            end
            default: state_q <= S_REQ;
         endcase
      end
   end

   assign imem_req_valid_o = (state_q == S_REQ);
   assign imem_req_addr_o  = pc_q;
   assign imem_rsp_ready_o = (state_q == S_WAIT);
   assign inst_valid_o     = (state_q == S_VALID);
   assign inst_o           = inst_q;
   assign inst_pc_o        = instPc_q;
   assign fetch_fault_o    = fault_q;
   assign pc_o             = pc_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: directed scenarios followed by randomized
// fetch traffic judged against transaction-level fetch rules.
module tb_ifu_fetch;

   localparam int          TIMEOUT  = 16;
   localparam logic [31:0] RESET_PC = 32'h8000_0000;

   logic        clk;
   logic        rst_n;
   logic        pcNextValid;
   logic [31:0] pcNext;
   logic        reqValid;
   logic        reqReady;
   logic [31:0] reqAddr;
   logic        rspValid;
   logic        rspReady;
   logic [31:0] rspData;
   logic        rspErr;
   logic        instValid;
   logic        instReady;
   logic [31:0] inst;
   logic [31:0] instPc;
   logic        fetchFault;
   logic [31:0] pc;

   int          checksTotal  = 0;
   int          checksPassed = 0;
   logic [31:0] holdData;
   logic [65:0] expView;

   ifu_fetch #(
      .RESET_PC (RESET_PC),
      .TIMEOUT  (TIMEOUT)
   ) dut (
      .clk_i            (clk),
      .rst_ni           (rst_n),
      .pc_next_valid_i  (pcNextValid),
      .pc_next_i        (pcNext),
      .imem_req_valid_o (reqValid),
      .imem_req_ready_i (reqReady),
      .imem_req_addr_o  (reqAddr),
      .imem_rsp_valid_i (rspValid),
      .imem_rsp_ready_o (rspReady),
      .imem_rsp_data_i  (rspData),
      .imem_rsp_err_i   (rspErr),
      .inst_valid_o     (instValid),
      .inst_ready_i     (instReady),
      .inst_o           (inst),
      .inst_pc_o        (instPc),
      .fetch_fault_o    (fetchFault),
      .pc_o             (pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clearInputs();
      pcNextValid = 1'b0;
      pcNext      = '0;
      reqReady    = 1'b0;
      rspValid    = 1'b0;
      rspData     = '0;
      rspErr      = 1'b0;
      instReady   = 1'b0;
   endtask

   // Hand decode's next PC over in the same cycle the current instruction is consumed.
   task automatic consumeWith(input logic [31:0] nextPc);
      instReady   = 1'b1;
      pcNextValid = 1'b1;
      pcNext      = nextPc;
      step();
      instReady   = 1'b0;
      pcNextValid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      clearInputs();
      step();
      step();
      checksTotal++;
      if (reqValid !== 1'b1) $display("[TB] FAIL reset_req_valid: got %b expected 1", reqValid);
      else checksPassed++;
      checksTotal++;
      if (reqAddr !== RESET_PC) $display("[TB] FAIL reset_req_addr: got %h expected %h", reqAddr, RESET_PC);
      else checksPassed++;
      checksTotal++;
      if ({rspReady, instValid} !== 2'b00) $display("[TB] FAIL reset_rsp_ready_inst_valid: got %b expected 00", {rspReady, instValid});
      else checksPassed++;
      checksTotal++;
      if (pc !== RESET_PC) $display("[TB] FAIL reset_pc: got %h expected %h", pc, RESET_PC);
      else checksPassed++;
      checksTotal++;
      if ({inst, instPc, fetchFault} !== 65'd0) $display("[TB] FAIL reset_buffer: got %h/%h/%b expected 0/0/0", inst, instPc, fetchFault);
      else checksPassed++;
   endtask

   task automatic test_zero_wait();
      rst_n = 1'b1;
      checksTotal++;
      if ({reqValid, reqAddr} !== {1'b1, RESET_PC}) $display("[TB] FAIL zw_first_req: got %b/%h expected 1/%h", reqValid, reqAddr, RESET_PC);
      else checksPassed++;
      reqReady = 1'b1;
      step();
      reqReady = 1'b0;
      checksTotal++;
      if ({rspReady, instValid} !== 2'b10) $display("[TB] FAIL zw_rsp_ready: got %b expected 10", {rspReady, instValid});
      else checksPassed++;
      rspValid = 1'b1;
      rspData  = 32'h0010_0093;
      step();
      rspValid = 1'b0;
      checksTotal++;
      if ({instValid, inst, instPc, fetchFault} !== {1'b1, 32'h0010_0093, RESET_PC, 1'b0})
         $display("[TB] FAIL zw_inst: got %b/%h/%h/%b expected 1/00100093/%h/0", instValid, inst, instPc, fetchFault, RESET_PC);
      else checksPassed++;
      consumeWith(32'h8000_0008);
   endtask

   task automatic test_backpressure();
      int accepted = 0;
      for (int i = 0; i < 6; i++) begin
         checksTotal++;
         if ({reqValid, reqAddr} !== {1'b1, 32'h8000_0008}) $display("[TB] FAIL bp_req_hold[%0d]: got %b/%h expected 1/80000008", i, reqValid, reqAddr);
         else checksPassed++;
         reqReady = (i == 5);
         if (reqValid && reqReady) accepted++;
         step();
      end
      holdData = $urandom;
      for (int i = 0; i < 4; i++) begin
         checksTotal++;
         if ({rspReady, instValid} !== 2'b10) $display("[TB] FAIL bp_wait[%0d]: got %b expected 10", i, {rspReady, instValid});
         else checksPassed++;
         rspValid = (i == 3);
         rspData  = holdData;
         if (reqValid && reqReady) accepted++;
         step();
      end
      rspValid = 1'b0;
      reqReady = 1'b0;
      checksTotal++;
      if ({instValid, inst, instPc, fetchFault} !== {1'b1, holdData, 32'h8000_0008, 1'b0})
         $display("[TB] FAIL bp_inst: got %b/%h/%h/%b expected 1/%h/80000008/0", instValid, inst, instPc, fetchFault, holdData);
      else checksPassed++;
      checksTotal++;
      if (accepted !== 1) $display("[TB] FAIL bp_req_count: got %0d expected 1", accepted);
      else checksPassed++;
   endtask

   task automatic test_hold_and_next();
      for (int i = 0; i < 4; i++) begin
         instReady = 1'b0;
         step();
         checksTotal++;
         if ({instValid, inst, instPc, fetchFault} !== {1'b1, holdData, 32'h8000_0008, 1'b0})
            $display("[TB] FAIL hold[%0d]: got %b/%h/%h/%b expected 1/%h/80000008/0", i, instValid, inst, instPc, fetchFault, holdData);
         else checksPassed++;
      end
      consumeWith(32'h8000_0004);
      checksTotal++;
      if ({reqValid, reqAddr, instValid, pc} !== {1'b1, 32'h8000_0004, 1'b0, 32'h8000_0004})
         $display("[TB] FAIL next_req: got %b/%h/%b/%h expected 1/80000004/0/80000004", reqValid, reqAddr, instValid, pc);
      else checksPassed++;
      reqReady = 1'b1;
      step();
      reqReady = 1'b0;
      rspValid = 1'b1;
      rspData  = $urandom;
      step();
      rspValid  = 1'b0;
      instReady = 1'b1;
      step();
      instReady = 1'b0;
      checksTotal++;
      if ({reqValid, rspReady, instValid} !== 3'b000) $display("[TB] FAIL next_idle: got %b expected 000", {reqValid, rspReady, instValid});
      else checksPassed++;
   endtask

   task automatic test_misaligned();
      pcNextValid = 1'b1;
      pcNext      = 32'h8000_0006;
      step();
      pcNextValid = 1'b0;
      checksTotal++;
      if (reqValid !== 1'b0) $display("[TB] FAIL mis_no_req: got %b expected 0", reqValid);
      else checksPassed++;
      checksTotal++;
      if ({instValid, inst, instPc, fetchFault, pc} !== {1'b1, 32'h0, 32'h8000_0006, 1'b1, 32'h8000_0006})
         $display("[TB] FAIL mis_inst: got %b/%h/%h/%b/%h expected 1/0/80000006/1/80000006", instValid, inst, instPc, fetchFault, pc);
      else checksPassed++;
      consumeWith(RESET_PC);
   endtask

   task automatic test_timeout();
      int waited = 0;
      reqReady = 1'b1;
      step();
      reqReady = 1'b0;
      while ((instValid !== 1'b1) && (waited < TIMEOUT + 4)) begin
         step();
         waited++;
      end
      checksTotal++;
      if (waited !== TIMEOUT) $display("[TB] FAIL timeout_cycles: got %0d expected %0d", waited, TIMEOUT);
      else checksPassed++;
      checksTotal++;
      if ({instValid, inst, instPc, fetchFault} !== {1'b1, 32'h0, RESET_PC, 1'b1})
         $display("[TB] FAIL timeout_inst: got %b/%h/%h/%b expected 1/0/%h/1", instValid, inst, instPc, fetchFault, RESET_PC);
      else checksPassed++;
      consumeWith(32'h8000_0020);
   endtask

   task automatic test_err();
      reqReady = 1'b1;
      step();
      reqReady = 1'b0;
      rspValid = 1'b1;
      rspData  = 32'hdead_beef;
      rspErr   = 1'b1;
      step();
      rspValid = 1'b0;
      rspErr   = 1'b0;
      checksTotal++;
      if ({instValid, inst, instPc, fetchFault} !== {1'b1, 32'hdead_beef, 32'h8000_0020, 1'b1})
         $display("[TB] FAIL err_inst: got %b/%h/%h/%b expected 1/deadbeef/80000020/1", instValid, inst, instPc, fetchFault);
      else checksPassed++;
      consumeWith(32'h8000_0010);
      reqReady = 1'b1;
      step();
      reqReady = 1'b0;
      checksTotal++;
      if ({rspReady, pc} !== {1'b1, 32'h8000_0010}) $display("[TB] FAIL err_next_wait: got %b/%h expected 1/80000010", rspReady, pc);
      else checksPassed++;
   endtask

   task automatic test_reset_mid();
      rst_n = 1'b0;
      #1;
      checksTotal++;
      if ({pc, rspReady, instValid, reqValid, reqAddr} !== {RESET_PC, 1'b0, 1'b0, 1'b1, RESET_PC})
         $display("[TB] FAIL midrst_outputs: got %h/%b/%b/%b/%h expected %h/0/0/1/%h", pc, rspReady, instValid, reqValid, reqAddr, RESET_PC, RESET_PC);
      else checksPassed++;
      clearInputs();
      step();
      step();
      rst_n = 1'b1;
      checksTotal++;
      if ({reqValid, reqAddr} !== {1'b1, RESET_PC}) $display("[TB] FAIL midrst_fresh_req: got %b/%h expected 1/%h", reqValid, reqAddr, RESET_PC);
      else checksPassed++;
      reqReady = 1'b1;
      step();
      reqReady = 1'b0;
      rspValid = 1'b1;
      rspData  = 32'h0000_0013;
      step();
      rspValid = 1'b0;
      expView  = {1'b1, 32'h0000_0013, RESET_PC, 1'b0};
      checksTotal++;
      if ({instValid, inst, instPc, fetchFault} !== expView) $display("[TB] FAIL midrst_inst: got %h expected %h", {instValid, inst, instPc, fetchFault}, expView);
      else checksPassed++;
   endtask

   // Each pass: decode may stall, then a new PC arrives; the fetch outcome follows
   // from the PC alignment, the memory delay versus TIMEOUT, and the error bit.
   task automatic test_random();
      for (int t = 0; t < 40; t++) begin
         int          hold;
         int          idle;
         int          reqDelay;
         int          rspDelay;
         int          lim;
         int          sel;
         logic [31:0] nextPc;
         logic [31:0] data;
         logic        err;

         hold = int'($urandom_range(0, 2));
         for (int h = 0; h < hold; h++) begin
            instReady = 1'b0;
            step();
            checksTotal++;
            if ({instValid, inst, instPc, fetchFault} !== expView) $display("[TB] FAIL rnd_hold[%0d]: got %h expected %h", t, {instValid, inst, instPc, fetchFault}, expView);
            else checksPassed++;
         end

         nextPc = RESET_PC + ($urandom_range(0, 1023) << 2);
         if ($urandom_range(0, 4) == 0) nextPc = nextPc + $urandom_range(1, 3);

         if ($urandom_range(0, 1) == 1) begin
            consumeWith(nextPc);
         end else begin
            instReady = 1'b1;
            step();
            instReady = 1'b0;
            idle = int'($urandom_range(0, 2));
            for (int k = 0; k <= idle; k++) begin
               checksTotal++;
               if ({reqValid, rspReady, instValid} !== 3'b000) $display("[TB] FAIL rnd_idle[%0d]: got %b expected 000", t, {reqValid, rspReady, instValid});
               else checksPassed++;
               pcNextValid = (k == idle);
               pcNext      = nextPc;
               step();
            end
            pcNextValid = 1'b0;
         end

         checksTotal++;
         if (pc !== nextPc) $display("[TB] FAIL rnd_pc[%0d]: got %h expected %h", t, pc, nextPc);
         else checksPassed++;

         if (nextPc[1:0] != 2'b00) begin
            expView = {1'b1, 32'h0, nextPc, 1'b1};
            checksTotal++;
            if (reqValid !== 1'b0) $display("[TB] FAIL rnd_mis_req[%0d]: got %b expected 0", t, reqValid);
            else checksPassed++;
         end else begin
            reqDelay = int'($urandom_range(0, 3));
            for (int k = 0; k <= reqDelay; k++) begin
               checksTotal++;
               if ({reqValid, reqAddr} !== {1'b1, nextPc}) $display("[TB] FAIL rnd_req[%0d]: got %b/%h expected 1/%h", t, reqValid, reqAddr, nextPc);
               else checksPassed++;
               reqReady = (k == reqDelay);
               rspValid = $urandom_range(0, 1) == 1;
               rspData  = $urandom;
               step();
            end
            reqReady = 1'b0;
            rspValid = 1'b0;

            sel = int'($urandom_range(0, 7));
            if (sel < 5) rspDelay = sel;
            else if (sel == 5) rspDelay = TIMEOUT - 1;
            else rspDelay = TIMEOUT;
            data = $urandom;
            err  = $urandom_range(0, 5) == 0;
            lim  = (rspDelay < TIMEOUT) ? rspDelay : TIMEOUT;
            for (int k = 0; k < lim; k++) begin
               checksTotal++;
               if ({rspReady, instValid} !== 2'b10) $display("[TB] FAIL rnd_wait[%0d]: got %b expected 10", t, {rspReady, instValid});
               else checksPassed++;
               step();
            end
            if (rspDelay < TIMEOUT) begin
               rspValid = 1'b1;
               rspData  = data;
               rspErr   = err;
               step();
               rspValid = 1'b0;
               rspErr   = 1'b0;
               expView  = {1'b1, data, nextPc, err};
            end else begin
               expView = {1'b1, 32'h0, nextPc, 1'b1};
            end
         end

         checksTotal++;
         if ({instValid, inst, instPc, fetchFault} !== expView) $display("[TB] FAIL rnd_result[%0d]: got %h expected %h", t, {instValid, inst, instPc, fetchFault}, expView);
         else checksPassed++;
      end
   endtask

   initial begin
      test_reset();
      test_zero_wait();
      test_backpressure();
      test_hold_and_next();
      test_misaligned();
      test_timeout();
      test_err();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", checksPassed, checksTotal);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
